draw_scheduler: RTL and testbench

- Upstream feeder for the rectangle rasterizer stage.
- Game logic (player, bullets, enemies, erase passes) pushes rectangle draw requests into an internal FIFO.
- The scheduler pops one request at a time, presents it to the rasterizer, pulses the rasterizer's load/reset, enables it, and waits for its done flag before issuing the next request.
- Provides backpressure to producers and an idle indication for frame sequencing.

---
 rtl/draw_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------
// draw_scheduler
//
// Feeds rectangle draw requests to the rectangle rasterizer. Producers push
// requests into a DEPTH-entry FIFO; the scheduler pops one request at a time,
// latches it onto the rast_* data outputs, strobes the rasterizer's active-low
// load/clear input for one cycle, lets it settle for one cycle, then enables
// it until rast_done is seen.
//
// Sequence per request: IDLE (pop) -> LOAD -> SETTLE -> RUN -> IDLE.
//
// Optional build macro:
//   DRAW_SCHED_TIMEOUT_EN
//     Adds a 12-bit RUN watchdog. After 4095 RUN cycles without rast_done the
//     current rectangle is abandoned, the sticky err flag is set and the
//     scheduler continues with the next request.
//     When undefined, RUN waits indefinitely and err is tied to 0.
//
// Ports:
//   clk          circuit clock
//   reset        asynchronous active-low reset
//   req_valid    producer has a request
//   req_ready    FIFO can accept (transfer on req_valid && req_ready)
//   req_x/y/w/h/c  request rectangle fields
//   rast_x/y/w/h/c latched rectangle fields to the rasterizer
//   rast_reset   active-low load/clear strobe to the rasterizer
//   rast_enable  rasterizer enable
//   rast_done    rasterizer finished current rectangle (level)
//   busy         high unless IDLE with an empty FIFO
//   count        FIFO occupancy, 0..DEPTH
//   err          sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module draw_scheduler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [6:0]  req_y,
  input  logic [4:0]  req_w,
  input  logic [4:0]  req_h,
  input  logic [2:0]  req_c,
  output logic [7:0]  rast_x,
  output logic [6:0]  rast_y,
  output logic [4:0]  rast_w,
  output logic [4:0]  rast_h,
  output logic [2:0]  rast_c,
  output logic        rast_reset,
  output logic        rast_enable,
  input  logic        rast_done,
  output logic        busy,
  output logic [AW:0] count,
  output logic        err
);

  // Entry layout: {x[7:0], y[6:0], w[4:0], h[4:0], c[2:0]}
  localparam int          EW      = 28;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Scheduler state and registered rasterizer interface
  state_t        r_state;
  logic [7:0]    r_rast_x;
  logic [6:0]    r_rast_y;
  logic [4:0]    r_rast_w;
  logic [4:0]    r_rast_h;
  logic [2:0]    r_rast_c;
  logic          r_rast_reset;
  logic          r_rast_enable;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_timeout;
  logic [EW-1:0] w_wr_data;
  logic [EW-1:0] w_head;

  assign w_ready   = (r_count != DEPTH_C);
  assign w_push    = req_valid && w_ready;
  // The head is consumed only when the scheduler is idle and has work.
  assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
  assign w_wr_data = {req_x, req_y, req_w, req_h, req_c};
  assign w_head    = r_mem[r_rd_ptr];

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam logic [11:0] WDOG_LAST = 12'd4094;

  logic [11:0] r_wdog;
  logic        r_err;

  // Abort on the RUN cycle whose increment would bring the watchdog to 4095,
  // i.e. after 4095 RUN cycles with no rast_done.
  assign w_timeout = (r_state == ST_RUN) && !rast_done && (r_wdog == WDOG_LAST);

  // Watchdog counter: cleared on the way into RUN, counts RUN cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= 12'd0;
    end else if (r_state == ST_SETTLE) begin
      r_wdog <= 12'd0;
    end else if (r_state == ST_RUN) begin
      r_wdog <= r_wdog + 12'd1;
    end else begin
      r_wdog <= r_wdog;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // FIFO pointers and occupancy; AW-bit pointers wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scheduler FSM. Outputs are registered on each transition so that the
  // rast_reset/rast_enable levels always match the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_rast_x      <= 8'd0;
      r_rast_y      <= 7'd0;
      r_rast_w      <= 5'd0;
      r_rast_h      <= 5'd0;
      r_rast_c      <= 3'd0;
      r_rast_reset  <= 1'b0;
      r_rast_enable <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rast_enable <= 1'b0;
          if (w_pop) begin
            // Data stays latched here until the next pop.
            r_rast_x     <= w_head[27:20];
            r_rast_y     <= w_head[19:13];
            r_rast_w     <= w_head[12:8];
            r_rast_h     <= w_head[7:3];
            r_rast_c     <= w_head[2:0];
            r_rast_reset <= 1'b0;
            r_state      <= ST_LOAD;
          end else begin
            r_rast_reset <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_rast_reset  <= 1'b1;
          r_rast_enable <= 1'b0;
          r_state       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // rast_done may still be stale from the previous rectangle; it is
          // deliberately not looked at until RUN.
          r_rast_reset  <= 1'b1;
          r_rast_enable <= 1'b1;
          r_state       <= ST_RUN;
        end
        ST_RUN: begin
          r_rast_reset <= 1'b1;
          if (rast_done || w_timeout) begin
            r_rast_enable <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_rast_enable <= 1'b1;
            r_state       <= ST_RUN;
          end
        end
        default: begin
          r_rast_reset  <= 1'b1;
          r_rast_enable <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign rast_x      = r_rast_x;
  assign rast_y      = r_rast_y;
  assign rast_w      = r_rast_w;
  assign rast_h      = r_rast_h;
  assign rast_c      = r_rast_c;
  assign rast_reset  = r_rast_reset;
  assign rast_enable = r_rast_enable;
  assign busy        = (r_state != ST_IDLE) || (r_count != '0);
  assign count       = r_count;

endmodule

// File: tb/tb_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_draw_scheduler
//
// Self-checking bench for draw_scheduler. Accepted requests are pushed to a
// scoreboard queue; every issue to the rasterizer (falling edge of
// rast_reset) pops the queue and compares the latched rectangle fields.
// A small rasterizer model can raise rast_done after a programmable number
// of enabled cycles, optionally leaving it stale-high afterwards.
// All driving and sampling happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_draw_scheduler;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] c;
  } req_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = 8'd0;
  logic [6:0] req_y = 7'd0;
  logic [4:0] req_w = 5'd0;
  logic [4:0] req_h = 5'd0;
  logic [2:0] req_c = 3'd0;
  logic [7:0] rast_x;
  logic [6:0] rast_y;
  logic [4:0] rast_w;
  logic [4:0] rast_h;
  logic [2:0] rast_c;
  logic       rast_reset;
  logic       rast_enable;
  logic       rast_done = 1'b0;
  logic       busy;
  logic [3:0] count;
  logic       err;

  req_t exp_q[$];
  req_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_issued = 0;
  int   en_total = 0;
  int   en_cnt = 0;
  int   run_len = 2;
  bit   model_auto = 1'b0;
  bit   stale_mode = 1'b0;
  bit   prev_rr = 1'b0;

  draw_scheduler #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_c(req_c),
    .rast_x(rast_x), .rast_y(rast_y), .rast_w(rast_w), .rast_h(rast_h), .rast_c(rast_c),
    .rast_reset(rast_reset), .rast_enable(rast_enable), .rast_done(rast_done),
    .busy(busy), .count(count), .err(err)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Scoreboard: each load strobe must match the oldest accepted request.
  always @(negedge clk) begin
    if (!reset) begin
      prev_rr = 1'b0;
    end else begin
      if (prev_rr && !rast_reset) begin
        n_issued = n_issued + 1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL issue_unexpected: got issue x=%0d, want no issue (queue empty)", rast_x);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rast_x, rast_y, rast_w, rast_h, rast_c} !== mon_e) begin
            failures = failures + 1;
            $display("FAIL issue_fields: got x=%0d y=%0d w=%0d h=%0d c=%0d, want x=%0d y=%0d w=%0d h=%0d c=%0d",
                     rast_x, rast_y, rast_w, rast_h, rast_c,
                     mon_e.x, mon_e.y, mon_e.w, mon_e.h, mon_e.c);
          end
        end
      end
      prev_rr = rast_reset;
    end
  end

  // Rasterizer model: done after run_len enabled cycles; in stale mode done
  // stays high until the rasterizer is enabled again.
  always @(negedge clk) begin
    if (!reset) begin
      en_cnt = 0;
      if (model_auto) rast_done = 1'b0;
    end else begin
      if (rast_enable) begin
        en_cnt = en_cnt + 1;
        en_total = en_total + 1;
      end else begin
        en_cnt = 0;
      end
      if (model_auto) begin
        if (rast_enable) rast_done = (en_cnt >= run_len);
        else if (!stale_mode) rast_done = 1'b0;
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following
  // acceptance, leaving req_valid high.
  task automatic push_req(input logic [7:0] x, input logic [6:0] y, input logic [4:0] w,
                          input logic [4:0] h, input logic [2:0] c);
    int waited;
    waited = 0;
    req_valid = 1'b1;
    req_x = x; req_y = y; req_w = w; req_h = h; req_c = c;
    while (!req_ready && waited < 2000) begin
      @(negedge clk);
      waited = waited + 1;
    end
    if (!req_ready) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL push_timeout: got req_ready=0 for %0d cycles, want 1", waited);
    end else begin
      exp_q.push_back({x, y, w, h, c});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    model_auto = 1'b0;
    stale_mode = 1'b0;
    rast_done = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_enable(input string tag);
    int k;
    k = 0;
    while (!rast_enable && k < 200) begin
      @(negedge clk);
      k = k + 1;
    end
    checks = checks + 1;
    if (!rast_enable) begin
      failures = failures + 1;
      $display("FAIL %s_enable_timeout: got rast_enable=0 after %0d cycles, want 1", tag, k);
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      k = k + 1;
    end
    checks = checks + 1;
    if (busy || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s_drain: got busy=%0d pending=%0d, want busy=0 pending=0", tag, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({count, req_ready, busy, rast_reset, rast_enable, err} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures = failures + 1;
      $display("FAIL reset_ctrl: got count=%0d ready=%0d busy=%0d rreset=%0d en=%0d err=%0d, want 0 1 0 0 0 0",
               count, req_ready, busy, rast_reset, rast_enable, err);
    end
    checks = checks + 1;
    if ({rast_x, rast_y, rast_w, rast_h, rast_c} !== 28'd0) begin
      failures = failures + 1;
      $display("FAIL reset_data: got %h, want 0", {rast_x, rast_y, rast_w, rast_h, rast_c});
    end
    reset = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (rast_reset !== 1'b1 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_idle: got rreset=%0d busy=%0d, want 1 0", rast_reset, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_req(8'd10, 7'd20, 5'd3, 5'd2, 3'b100);
    req_valid = 1'b0;
    // Cycle N+1: accepted, still idle.
    checks = checks + 1;
    if (count !== 4'd1 || rast_reset !== 1'b1 || rast_enable !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL single_n1: got count=%0d rreset=%0d en=%0d, want 1 1 0", count, rast_reset, rast_enable);
    end
    @(negedge clk);
    // Cycle N+2: LOAD.
    checks = checks + 1;
    if (rast_reset !== 1'b0 || rast_enable !== 1'b0 || rast_x !== 8'd10 || rast_y !== 7'd20 || busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL single_load: got rreset=%0d en=%0d x=%0d y=%0d busy=%0d, want 0 0 10 20 1",
               rast_reset, rast_enable, rast_x, rast_y, busy);
    end
    @(negedge clk);
    // Cycle N+3: SETTLE.
    checks = checks + 1;
    if (rast_reset !== 1'b1 || rast_enable !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL single_settle: got rreset=%0d en=%0d, want 1 0", rast_reset, rast_enable);
    end
    @(negedge clk);
    // Cycle N+4: RUN.
    checks = checks + 1;
    if (rast_enable !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL single_run: got en=%0d, want 1", rast_enable);
    end
    repeat (2) @(negedge clk);
    rast_done = 1'b1;
    @(negedge clk);
    rast_done = 1'b0;
    checks = checks + 1;
    if (rast_enable !== 1'b0 || busy !== 1'b0 || rast_x !== 8'd10 || rast_c !== 3'b100) begin
      failures = failures + 1;
      $display("FAIL single_done: got en=%0d busy=%0d x=%0d c=%0d, want 0 0 10 4", rast_enable, busy, rast_x, rast_c);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    do_reset();
    n0 = n_issued;
    for (int i = 0; i < 9; i++) begin
      push_req(8'(i), 7'(i + 1), 5'd1, 5'd1, 3'(i));
    end
    checks = checks + 1;
    if (count !== 4'd8 || req_ready !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL full_level: got count=%0d ready=%0d, want 8 0", count, req_ready);
    end
    // Push while full must be ignored.
    req_x = 8'd99;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    checks = checks + 1;
    if (count !== 4'd8) begin
      failures = failures + 1;
      $display("FAIL full_ignore: got count=%0d, want 8", count);
    end
    run_len = 2;
    model_auto = 1'b1;
    wait_drain("b2b", 600);
    checks = checks + 1;
    if (n_issued - n0 !== 9) begin
      failures = failures + 1;
      $display("FAIL b2b_issued: got %0d, want 9", n_issued - n0);
    end
  endtask

  task automatic test_stale_done();
    int e0;
    int n0;
    do_reset();
    model_auto = 1'b1;
    stale_mode = 1'b1;
    run_len = 3;
    e0 = en_total;
    n0 = n_issued;
    push_req(8'd30, 7'd1, 5'd2, 5'd2, 3'd1);
    push_req(8'd31, 7'd2, 5'd2, 5'd2, 3'd2);
    req_valid = 1'b0;
    wait_drain("stale", 200);
    checks = checks + 1;
    if (en_total - e0 !== 6 || n_issued - n0 !== 2) begin
      failures = failures + 1;
      $display("FAIL stale_enable: got en_cycles=%0d issued=%0d, want 6 2", en_total - e0, n_issued - n0);
    end
    checks = checks + 1;
    if (rast_x !== 8'd31) begin
      failures = failures + 1;
      $display("FAIL stale_last: got x=%0d, want 31", rast_x);
    end
  endtask

  task automatic test_push_pop();
    int n0;
    do_reset();
    n0 = n_issued;
    push_req(8'd5, 7'd5, 5'd1, 5'd1, 3'd5);
    push_req(8'd6, 7'd6, 5'd1, 5'd1, 3'd6);
    req_valid = 1'b0;
    wait_enable("pushpop");
    rast_done = 1'b1;
    @(negedge clk);
    rast_done = 1'b0;
    checks = checks + 1;
    if (count !== 4'd1 || rast_enable !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL pushpop_pre: got count=%0d en=%0d, want 1 0", count, rast_enable);
    end
    // This push lands on the same edge as the pop of entry 6.
    push_req(8'd7, 7'd7, 5'd1, 5'd1, 3'd7);
    req_valid = 1'b0;
    checks = checks + 1;
    if (count !== 4'd1 || rast_reset !== 1'b0 || rast_x !== 8'd6) begin
      failures = failures + 1;
      $display("FAIL pushpop_count: got count=%0d rreset=%0d x=%0d, want 1 0 6", count, rast_reset, rast_x);
    end
    run_len = 2;
    model_auto = 1'b1;
    wait_drain("pushpop", 200);
    checks = checks + 1;
    if (n_issued - n0 !== 3 || count !== 4'd0) begin
      failures = failures + 1;
      $display("FAIL pushpop_issued: got issued=%0d count=%0d, want 3 0", n_issued - n0, count);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_req(8'(40 + i), 7'd3, 5'd1, 5'd1, 3'd3);
    end
    req_valid = 1'b0;
    wait_enable("midrst");
    checks = checks + 1;
    if (count !== 4'd3) begin
      failures = failures + 1;
      $display("FAIL midrst_queued: got count=%0d, want 3", count);
    end
    n0 = n_issued;
    reset = 1'b0;
    #1;
    checks = checks + 1;
    if (count !== 4'd0 || rast_enable !== 1'b0 || rast_reset !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL midrst_now: got count=%0d en=%0d rreset=%0d busy=%0d ready=%0d, want 0 0 0 0 1",
               count, rast_enable, rast_reset, busy, req_ready);
    end
    exp_q.delete();
    @(negedge clk);
    model_auto = 1'b1;
    run_len = 2;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks = checks + 1;
    if (n_issued !== n0 || busy !== 1'b0 || count !== 4'd0) begin
      failures = failures + 1;
      $display("FAIL midrst_after: got issued=%0d busy=%0d count=%0d, want %0d 0 0", n_issued, busy, count, n0);
    end
  endtask

`ifdef DRAW_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    int en_run;
    int n0;
    do_reset();
    push_req(8'd50, 7'd4, 5'd1, 5'd1, 3'd1);
    push_req(8'd51, 7'd5, 5'd1, 5'd1, 3'd2);
    req_valid = 1'b0;
    wait_enable("timeout");
    n0 = n_issued;
    k = 0;
    en_run = 0;
    while (!err && k < 5000) begin
      if (rast_enable) en_run = en_run + 1;
      @(negedge clk);
      k = k + 1;
    end
    checks = checks + 1;
    if (err !== 1'b1 || en_run !== 4095 || rast_enable !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL timeout_err: got err=%0d run_cycles=%0d en=%0d, want 1 4095 0", err, en_run, rast_enable);
    end
    wait_enable("timeout_next");
    checks = checks + 1;
    if (n_issued - n0 !== 1 || rast_x !== 8'd51 || err !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL timeout_next: got issued=%0d x=%0d err=%0d, want 1 51 1", n_issued - n0, rast_x, err);
    end
    run_len = 2;
    model_auto = 1'b1;
    wait_drain("timeout", 100);
    checks = checks + 1;
    if (err !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL timeout_sticky: got err=%0d, want 1", err);
    end
    do_reset();
    checks = checks + 1;
    if (err !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL timeout_clear: got err=%0d, want 0", err);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    push_req(8'd60, 7'd6, 5'd1, 5'd1, 3'd6);
    req_valid = 1'b0;
    wait_enable("nowdog");
    repeat (4200) @(negedge clk);
    checks = checks + 1;
    if (rast_enable !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL nowdog_wait: got en=%0d err=%0d busy=%0d, want 1 0 1", rast_enable, err, busy);
    end
    rast_done = 1'b1;
    @(negedge clk);
    rast_done = 1'b0;
    wait_drain("nowdog", 50);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale_done();
    test_push_pop();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
